// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the counter-width helper.
package sub_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Counter width for a WIDTH-bit operation; never narrower than one bit so
  // WIDTH=1 still has a legal counter.
  function automatic int cnt_width(input int w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor, LSB first, one bit per clock with start/done
// handshake. A single full_sub cell is reused for every bit position.
// Optional macro SERIAL_SUB_SAT_EN: clamp diff to 0 when the final borrow
// is set (borrow is still reported).
module serial_sub
  import sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = cnt_width(WIDTH);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             bin;
  logic             d;
  logic             bout;
  logic             last;

  full_sub u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (bin),
    .d    (d),
    .bout (bout)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  // Result register with the new difference bit entering at the MSB; after
  // WIDTH shifts the LSB of the result sits at bit 0.
  always_comb begin
    res_next            = res >> 1;
    res_next[WIDTH-1]   = d;
  end

  // FSM, operand/result shifting, borrow chain and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      bin    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // DONE accepts a new request too, giving back-to-back operation.
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            bin   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          // start, a and b are ignored here; only the shifted copies matter.
          res  <= res_next;
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          bin  <= bout;
          cnt  <= cnt + CW'(1);
          if (last) begin
`ifdef SERIAL_SUB_SAT_EN
            diff <= bout ? '0 : res_next;
`else
            diff <= res_next;
`endif
            borrow <= bout;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: WIDTH=8 instance for the main scenarios
// and a WIDTH=1 instance for the single-bit case, against an arithmetic model.
module tb_serial_sub;

  logic       clk = 1'b0;
  logic       rst_n, start, start1;
  logic [7:0] a, b, diff;
  logic       busy, done, borrow;
  logic [0:0] a1, b1, diff1;
  logic       busy1, done1, borrow1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow)
  );

  serial_sub #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
  );

  // Reference: integer subtraction, borrow when the true result is negative.
  function automatic logic [8:0] ref_sub(input int x, input int y, input int w);
    int   v;
    logic br;
    int   r;
    v  = x - y;
    br = (v < 0);
    r  = (v + (1 << w)) % (1 << w);
`ifdef SERIAL_SUB_SAT_EN
    if (br) r = 0;
`endif
    return {br, 8'(r)};
  endfunction

  // Launch one 8-bit operation and follow it to done (bounded). Scrambles a/b
  // during RUN; optionally re-asserts start with FF/FF at cycle restart_at.
  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input int restart_at,
                       output int lat, output int busy_cnt,
                       output logic [7:0] d, output logic br, output bit stable);
    logic [7:0] held;
    int n;
    @(negedge clk); a = x; b = y; start = 1'b1; held = diff;
    @(posedge clk); #1 start = 1'b0; a = 8'($urandom); b = 8'($urandom);
    n = 0; busy_cnt = 0; stable = 1'b1; lat = -1;
    while (n < 40) begin
      @(negedge clk);
      if (done) begin lat = n; break; end
      if (diff !== held) stable = 1'b0;
      if (busy) busy_cnt++;
      if (n == restart_at) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
      @(posedge clk); n++; #1 start = 1'b0;
    end
    d = diff; br = borrow;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({busy, done, diff, borrow} !== 11'd0) begin failures++;
      $display("FAIL reset8 got=%b/%b/%h/%b want=0/0/00/0", busy, done, diff, borrow); end
    checks++; if ({busy1, done1, diff1, borrow1} !== 4'd0) begin failures++;
      $display("FAIL reset1 got=%b/%b/%b/%b want=0/0/0/0", busy1, done1, diff1, borrow1); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat, bc; logic [7:0] d; logic br; bit st;
    do_op(8'h35, 8'h12, -1, lat, bc, d, br, st);
    checks++; if (lat !== 8) begin failures++; $display("FAIL basic_latency got=%0d want=8", lat); end
    checks++; if (bc !== 8) begin failures++; $display("FAIL basic_busy_cycles got=%0d want=8", bc); end
    checks++; if (d !== 8'h23) begin failures++; $display("FAIL basic_diff got=%h want=23", d); end
    checks++; if (br !== 1'b0) begin failures++; $display("FAIL basic_borrow got=%b want=0", br); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done got=%b want=0", busy); end
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL basic_diff_stable got=%b want=1", st); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b want=0", done); end
    checks++; if (diff !== 8'h23) begin failures++; $display("FAIL basic_diff_held got=%h want=23", diff); end
  endtask

  task automatic test_underflow();
    int lat, bc; logic [7:0] d; logic br; bit st; logic [8:0] e;
    e = ref_sub(0, 1, 8);
    do_op(8'h00, 8'h01, -1, lat, bc, d, br, st);
    checks++; if ({br, d} !== e) begin failures++;
      $display("FAIL underflow got=%b/%h want=%b/%h", br, d, e[8], e[7:0]); end
    checks++; if (br !== 1'b1) begin failures++; $display("FAIL underflow_borrow got=%b want=1", br); end
  endtask

  task automatic test_equal();
    int lat, bc; logic [7:0] d; logic br; bit st; logic [7:0] v;
    v = 8'($urandom);
    do_op(v, v, -1, lat, bc, d, br, st);
    checks++; if ({br, d} !== 9'd0) begin failures++;
      $display("FAIL equal_%h got=%b/%h want=0/00", v, br, d); end
  endtask

  task automatic test_start_busy();
    int lat, bc, extra; logic [7:0] d; logic br; bit st;
    do_op(8'h10, 8'h01, 3, lat, bc, d, br, st);
    checks++; if (lat !== 8) begin failures++; $display("FAIL busy_start_latency got=%0d want=8", lat); end
    checks++; if ({br, d} !== 9'h00F) begin failures++; $display("FAIL busy_start_diff got=%b/%h want=0/0f", br, d); end
    extra = 0;
    repeat (12) begin @(negedge clk); if (done || busy) extra++; end
    checks++; if (extra !== 0) begin failures++; $display("FAIL busy_start_second_op got=%0d want=0", extra); end
  endtask

  task automatic test_back_to_back();
    int cyc, first, second;
    @(negedge clk); a = 8'h80; b = 8'h80; start = 1'b1;
    cyc = 0; first = -1; second = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); cyc++;
      @(negedge clk); if (done) begin first = cyc; break; end
    end
    checks++; if ({borrow, diff} !== 9'd0) begin failures++; $display("FAIL b2b_first got=%b/%h want=0/00", borrow, diff); end
    @(posedge clk); cyc++; #1 start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); if (done) begin second = cyc; break; end
      @(posedge clk); cyc++;
    end
    checks++; if (first < 0 || second - first !== 9) begin failures++;
      $display("FAIL b2b_interval got=%0d want=9", second - first); end
    checks++; if ({borrow, diff} !== 9'd0) begin failures++; $display("FAIL b2b_second got=%b/%h want=0/00", borrow, diff); end
  endtask

  task automatic test_reset_mid();
    int lat, bc; logic [7:0] d, x, y; logic br; bit st; logic [8:0] e;
    do_op(8'h35, 8'h12, -1, lat, bc, d, br, st);
    @(negedge clk); a = 8'h77; b = 8'h11; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if ({busy, done, diff, borrow} !== 11'd0) begin failures++;
      $display("FAIL reset_mid got=%b/%b/%h/%b want=0/0/00/0", busy, done, diff, borrow); end
    rst_n = 1'b1;
    x = 8'($urandom); y = 8'($urandom); e = ref_sub(int'(x), int'(y), 8);
    do_op(x, y, -1, lat, bc, d, br, st);
    checks++; if ({br, d} !== e || lat !== 8) begin failures++;
      $display("FAIL reset_mid_after got=%b/%h lat=%0d want=%b/%h lat=8", br, d, lat, e[8], e[7:0]); end
  endtask

  task automatic test_random();
    int lat, bc; logic [7:0] d, x, y; logic br; bit st; logic [8:0] e;
    for (int i = 0; i < 20; i++) begin
      x = 8'($urandom); y = 8'($urandom); e = ref_sub(int'(x), int'(y), 8);
      do_op(x, y, -1, lat, bc, d, br, st);
      checks++; if ({br, d} !== e || lat !== 8 || bc !== 8) begin failures++;
        $display("FAIL random_%h_%h got=%b/%h lat=%0d busy=%0d want=%b/%h lat=8 busy=8",
                 x, y, br, d, lat, bc, e[8], e[7:0]); end
    end
  endtask

  task automatic test_width1();
    logic [1:0] ab; logic [8:0] e;
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i); e = ref_sub(int'(ab[1]), int'(ab[0]), 1);
      @(negedge clk); a1 = ab[1]; b1 = ab[0]; start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
      @(negedge clk);
      checks++; if (busy1 !== 1'b1 || done1 !== 1'b0) begin failures++;
        $display("FAIL w1_busy_%b got=%b/%b want=1/0", ab, busy1, done1); end
      @(posedge clk); @(negedge clk);
      checks++; if ({done1, borrow1, diff1} !== {1'b1, e[8], e[0]}) begin failures++;
        $display("FAIL w1_result_%b got=%b/%b/%b want=1/%b/%b", ab, done1, borrow1, diff1, e[8], e[0]); end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0;
    a = '0; b = '0; a1 = '0; b1 = '0;
    test_reset();
    test_basic();
    test_underflow();
    test_equal();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_width1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
